// File: rtl/ctrl_pkg.sv
// Shared RV32I control encodings: opcode classes, FSM states, datapath mux selects.
// Immediate generator imports the same opcode constants so decode stays consistent.
package ctrl_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  typedef struct packed {
    logic op;
    logic op_imm;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic nop;
  } cls_t;

  function automatic logic [1:0] alu_a_of(input cls_t c);
    if (c.lui)   return ALU_A_ZERO;
    if (c.auipc) return ALU_A_PC;
    return ALU_A_RS1;
  endfunction

  function automatic logic alu_b_of(input cls_t c);
    return c.op_imm | c.load | c.store | c.lui | c.auipc;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: inst -> one-hot class plus illegal flag.
// Illegal encodings are reported as the NOP class so the default build just skips them.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output cls_t        cls,
  output logic        illegal
);

  logic w_known;
  logic w_unused_inst;

  assign w_unused_inst = ^inst[31:7];

  always_comb begin
    cls     = '0;
    w_known = 1'b1;
    case (inst[6:2])
      OPC_OP:       cls.op     = 1'b1;
      OPC_OP_IMM:   cls.op_imm = 1'b1;
      OPC_LOAD:     cls.load   = 1'b1;
      OPC_STORE:    cls.store  = 1'b1;
      OPC_BRANCH:   cls.branch = 1'b1;
      OPC_JAL:      cls.jal    = 1'b1;
      OPC_JALR:     cls.jalr   = 1'b1;
      OPC_LUI:      cls.lui    = 1'b1;
      OPC_AUIPC:    cls.auipc  = 1'b1;
      OPC_MISC_MEM,
      OPC_SYSTEM:   cls.nop    = 1'b1;
      default:      w_known    = 1'b0;
    endcase
    illegal = !w_known || (inst[1:0] != 2'b11);
    if (illegal) begin
      cls     = '0;
      cls.nop = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle sequencer: 3 (branch/nop), 4, or 5 (load) cycles per instruction, +1 per memory wait.
// FETCH/MEM hold mem_req until mem_ready; MULTICYCLE_CTRL_TRAP_EN parks illegal instructions in TRAP.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [2:0]  state
);

  state_t r_state;
  state_t w_nxt;
  cls_t   w_cls;
  logic   w_illegal;

  ctrl_decode u_decode (
    .inst    (inst),
    .cls     (w_cls),
    .illegal (w_illegal)
  );

`ifndef MULTICYCLE_CTRL_TRAP_EN
  logic w_unused_illegal;
  assign w_unused_illegal = w_illegal;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_nxt;
  end

  assign state = rst ? 3'(ST_FETCH) : 3'(r_state);

  always_comb begin
    w_nxt        = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = ALU_A_RS1;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    trap         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          w_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_nxt = ST_EXEC;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        if (w_illegal) w_nxt = ST_TRAP;
`endif
      end
      ST_EXEC: begin
        alu_a_sel = alu_a_of(w_cls);
        alu_b_sel = alu_b_of(w_cls);
        if (w_cls.branch || w_cls.nop) begin
          pc_we  = 1'b1;
          pc_sel = (w_cls.branch && br_taken) ? PC_IMM : PC_PLUS4;
          retire = 1'b1;
          w_nxt  = ST_FETCH;
        end else if (w_cls.load || w_cls.store) begin
          w_nxt = ST_MEM;
        end else begin
          w_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_cls.store;
        if (mem_ready) begin
          if (w_cls.store) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            w_nxt  = ST_FETCH;
          end else begin
            w_nxt = ST_WB;
          end
        end
      end
      ST_WB: begin
        // ALU selects stay at their EXEC values so the result is still valid here
        alu_a_sel = alu_a_of(w_cls);
        alu_b_sel = alu_b_of(w_cls);
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        wb_sel    = w_cls.load ? WB_MEM : ((w_cls.jal || w_cls.jalr) ? WB_PC4 : WB_ALU);
        pc_sel    = w_cls.jal ? PC_IMM : (w_cls.jalr ? PC_JALR : PC_PLUS4);
        w_nxt     = ST_FETCH;
      end
`ifdef MULTICYCLE_CTRL_TRAP_EN
      ST_TRAP: begin
        trap = 1'b1;
      end
`endif
      default: w_nxt = ST_FETCH;
    endcase
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = PC_PLUS4;
      alu_a_sel    = ALU_A_RS1;
      alu_b_sel    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = WB_ALU;
      retire       = 1'b0;
      trap         = 1'b0;
    end
  end

endmodule
